// File: rtl/subtractor_defs.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package subtractor_defs;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fullsubtractor.sv
// One-bit full subtractor (a - b - bin) built from two cascaded half subtractors.
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d_ab;
  logic bo_ab;
  logic bo_bin;

  halfsubtractor u_hs_ab (
    .x  (a),
    .y  (b),
    .d  (d_ab),
    .bo (bo_ab)
  );

  // Second stage removes the incoming borrow from the partial difference.
  halfsubtractor u_hs_bin (
    .x  (d_ab),
    .y  (bin),
    .d  (d),
    .bo (bo_bin)
  );

  assign bout = bo_ab | bo_bin;

endmodule

// File: rtl/halfsubtractor.sv
// One-bit half subtractor: difference x ^ y, borrow when x is 0 and y is 1.
module halfsubtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: processes one bit per clock, LSB first,
// and pulses done for one cycle once all WIDTH bits have been consumed.
module serial_subtractor
  import subtractor_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             borrow_q;
  logic [CW-1:0]    bit_cnt;
  logic             busy_q;
  logic             done_q;
  logic             d_bit;
  logic             bout_bit;

  fullsubtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; blocking assignments would let the operand shift
  // feed into the full subtractor within the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      diff_sr  <= '0;
      borrow_q <= 1'b0;
      bit_cnt  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr     <= a;
            b_sr     <= b;
            borrow_q <= 1'b0;
            bit_cnt  <= '0;
            busy_q   <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Difference bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
          diff_sr  <= (diff_sr >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          borrow_q <= bout_bit;
          bit_cnt  <= bit_cnt + CW'(1);
          if (bit_cnt == LAST) begin
            done_q <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_sr;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1 against an
// arithmetic reference (a - b modulo 2^WIDTH, borrow = a < b).
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       borrow8;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       borrow1;

  int checks;
  int failures;
  int cyc;
  int done_cnt8;
  int done_cnt1;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start8),
    .a          (a8),
    .b          (b8),
    .busy       (busy8),
    .done       (done8),
    .diff       (diff8),
    .borrow_out (borrow8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .a          (a1),
    .b          (b1),
    .busy       (busy1),
    .done       (done1),
    .diff       (diff1),
    .borrow_out (borrow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done8) done_cnt8 <= done_cnt8 + 1;
    if (done1) done_cnt1 <= done_cnt1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain modular arithmetic.
  function automatic logic [7:0] ref_diff8(input logic [7:0] x, input logic [7:0] y);
    return 8'((int'(x) - int'(y) + 256) % 256);
  endfunction

  function automatic logic ref_borrow(input int x, input int y);
    return (x < y);
  endfunction

  // One WIDTH=8 operation from IDLE; optionally disturbs a/b/start in the 3rd RUN cycle.
  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input bit interfere);
    int n;
    int cnt_before;
    @(negedge clk);
    a8 = av;
    b8 = bv;
    start8 = 1'b1;
    cnt_before = done_cnt8;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_busy_run"}, busy8, 1);
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      if (interfere && n == 2) begin
        a8 = ~av;
        b8 = 8'($urandom);
        start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    start8 = 1'b0;
    check({tag, "_latency"}, n, 8);
    check({tag, "_diff"}, diff8, ref_diff8(av, bv));
    check({tag, "_borrow"}, borrow8, ref_borrow(int'(av), int'(bv)));
    check({tag, "_busy_done"}, busy8, 1);
    @(negedge clk);
    check({tag, "_done_single"}, done8, 0);
    check({tag, "_idle"}, busy8, 0);
    check({tag, "_diff_hold"}, diff8, ref_diff8(av, bv));
    check({tag, "_pulses"}, done_cnt8 - cnt_before, 1);
  endtask

  task automatic op1(input string tag, input logic av, input logic bv);
    int n;
    @(negedge clk);
    a1 = av;
    b1 = bv;
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 10) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, "_latency"}, n, 1);
    check({tag, "_diff"}, diff1, 32'((int'(av) - int'(bv) + 2) % 2));
    check({tag, "_borrow"}, borrow1, ref_borrow(int'(av), int'(bv)));
    @(negedge clk);
    check({tag, "_done_single"}, done1, 0);
  endtask

  initial begin
    int last_cyc;
    int n;
    int cnt_before;
    logic [7:0] ea;
    logic [7:0] eb;

    checks = 0;
    failures = 0;
    cyc = 0;
    done_cnt8 = 0;
    done_cnt1 = 0;
    rst_n = 1'b0;
    start8 = 1'b0;
    a8 = '0;
    b8 = '0;
    start1 = 1'b0;
    a1 = '0;
    b1 = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_diff", diff8, 0);
    check("rst_borrow", borrow8, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_hold_busy", busy8, 0);

    op8("ex_5a_3c", 8'h5A, 8'h3C, 1'b0);
    op8("ex_00_01", 8'h00, 8'h01, 1'b0);
    op8("ex_80_80", 8'h80, 8'h80, 1'b0);
    op8("ex_ff_00", 8'hFF, 8'h00, 1'b0);
    op8("interfere", 8'hC3, 8'h4E, 1'b1);

    for (int i = 0; i < 20; i++) begin
      op8("rand", 8'($urandom), 8'($urandom), 1'b0);
    end

    // Reset asserted mid-cycle during the 4th RUN cycle.
    @(negedge clk);
    a8 = 8'hFF;
    b8 = 8'h01;
    start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    cnt_before = done_cnt8;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy8, 0);
    check("arst_done", done8, 0);
    check("arst_diff", diff8, 0);
    check("arst_borrow", borrow8, 0);
    repeat (12) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("arst_no_done", done_cnt8 - cnt_before, 0);
    op8("after_rst", 8'h10, 8'h20, 1'b0);

    // Back-to-back with start held high; new operands presented during DONE.
    @(negedge clk);
    ea = 8'($urandom);
    eb = 8'($urandom);
    a8 = ea;
    b8 = eb;
    start8 = 1'b1;
    last_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (done8 !== 1'b1 && n < 40) begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end
      check("b2b_seen", done8, 1);
      check("b2b_diff", diff8, ref_diff8(ea, eb));
      check("b2b_borrow", borrow8, ref_borrow(int'(ea), int'(eb)));
      if (i > 0) check("b2b_interval", cyc - last_cyc, 10);
      last_cyc = cyc;
      ea = 8'($urandom);
      eb = 8'($urandom);
      a8 = ea;
      b8 = eb;
      if (i == 5) start8 = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("b2b_stop", busy8, 0);

    op1("w1_00", 1'b0, 1'b0);
    op1("w1_10", 1'b1, 1'b0);
    op1("w1_01", 1'b0, 1'b1);
    op1("w1_11", 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
